// File: rtl/alu_muldiv.sv
// MIPS-style ALU with a shared multi-cycle shift-add multiplier / restoring divider writing HI/LO.
// Define ALU_MULDIV_SIGNED_EN to add signed MULT/DIV (sign-magnitude around the unsigned datapath).
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [5:0]       control,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;
`ifdef ALU_MULDIV_SIGNED_EN
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_DIV   = 6'b011010;
`endif

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int CW = $clog2(WIDTH);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_mul, is_div, is_sgn, accept;
   logic               neg1, neg2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_diff;
   logic               rem_ge;
   logic [2*WIDTH-1:0] step_next;
   logic [WIDTH-1:0]   fin_hi, fin_lo;

   always_comb begin
      is_mul = (control == F_MULTU);
      is_div = (control == F_DIVU);
      is_sgn = 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      if (control == F_MULT) begin
         is_mul = 1'b1;
         is_sgn = 1'b1;
      end
      if (control == F_DIV) begin
         is_div = 1'b1;
         is_sgn = 1'b1;
      end
`endif
   end

   assign accept = start && (state_q != ST_RUN) && (is_mul || is_div);
   assign neg1   = is_sgn & op1[WIDTH-1];
   assign neg2   = is_sgn & op2[WIDTH-1];
   assign mag1   = neg1 ? ('0 - op1) : op1;
   assign mag2   = neg2 ? ('0 - op2) : op2;

   // prod_q holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, divisor_q} : '0);
   assign rem_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
   assign rem_ge   = (rem_sh >= {1'b0, divisor_q});
   assign rem_diff = rem_sh[WIDTH-1:0] - divisor_q;

   always_comb begin
      if (div_q)
         step_next = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), prod_q[WIDTH-2:0], rem_ge};
      else
         step_next = {mul_sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      fin_hi = step_next[2*WIDTH-1:WIDTH];
      fin_lo = step_next[WIDTH-1:0];
      if (div_q) begin
         if (neg_q)
            fin_lo = '0 - step_next[WIDTH-1:0];
         if (rneg_q)
            fin_hi = '0 - step_next[2*WIDTH-1:WIDTH];
      end else if (neg_q) begin
         {fin_hi, fin_lo} = (2*WIDTH)'(0) - step_next;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      divisor_d = divisor_q;
      div_d     = div_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_RUN: begin
            prod_d = step_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               hi_d    = fin_hi;
               lo_d    = fin_lo;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         cnt_d     = '0;
         prod_d    = {{WIDTH{1'b0}}, mag1};
         divisor_d = mag2;
         div_d     = is_div;
         neg_d     = neg1 ^ neg2;
         rneg_d    = neg1 & is_div;
         state_d   = ST_RUN;
         // Divide by zero bypasses the datapath and reports immediately.
         if (is_div && (op2 == '0)) begin
            state_d = ST_DONE;
            hi_d    = op1;
            lo_d    = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         prod_q    <= '0;
         divisor_q <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         divisor_q <= divisor_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         rneg_q    <= rneg_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      result = '0;
      case (control)
         F_ADD:   result = op1 + op2;
         F_SUB:   result = op1 - op2;
         F_AND:   result = op1 & op2;
         F_OR:    result = op1 | op2;
         F_XOR:   result = op1 ^ op2;
         F_NOR:   result = ~(op1 | op2);
         F_SLTU:  result[0] = (op1 < op2);
         F_MFHI:  result = hi_q;
         F_MFLO:  result = lo_q;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized scoreboard bench for alu_muldiv: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops on every done pulse and also checks busy each cycle.
module tb_alu_muldiv;
   localparam int W = 32;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  op1 = '0;
   logic [W-1:0]  op2 = '0;
   logic [5:0]    control = '0;
   logic          start = 1'b0;
   logic [W-1:0]  result, hi, lo;
   logic          zero, busy, done;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .op1(op1), .op2(op2), .control(control), .start(start),
      .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   exp_t         sbq[$];
   int           n_tests = 0;
   int           n_fail = 0;
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;
   int           busy_until = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      case (c)
         F_ADD:   return a + b;
         F_SUB:   return a - b;
         F_AND:   return a & b;
         F_OR:    return a | b;
         F_XOR:   return a ^ b;
         F_NOR:   return ~(a | b);
         F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         F_MFHI:  return model_hi;
         F_MFLO:  return model_lo;
         default: return '0;
      endcase
   endfunction

   task automatic ref_op(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output bit v);
      longint unsigned up;
      longint          sa, sb, sp;
      v  = 1'b0;
      h  = '0;
      l  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (c)
         F_MULTU: begin
            v = 1'b1;
            up = {32'h0, a} * {32'h0, b};
            {h, l} = up;
         end
         F_DIVU: begin
            v = 1'b1;
            if (b == 0) begin l = '1; h = a; end
            else begin l = a / b; h = a % b; end
         end
`ifdef ALU_MULDIV_SIGNED_EN
         F_MULT: begin
            v = 1'b1;
            sp = sa * sb;
            {h, l} = sp;
         end
         F_DIV: begin
            v = 1'b1;
            if (b == 0) begin l = '1; h = a; end
            else begin
               sp = sa / sb; l = sp[31:0];
               sp = sa % sb; h = sp[31:0];
            end
         end
`endif
         default: ;
      endcase
      if (sa == sb) sp = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      for (int k = 0; k < 200 && cyc < c; k++) tick();
   endtask

   // Issue a start; the model decides acceptance from whether the previous op has reached DONE.
   task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] h, l;
      bit           v;
      exp_t         e;
      ref_op(c, a, b, h, l, v);
      op1 = a; op2 = b; control = c; start = 1'b1;
      tick();
      start = 1'b0;
      if (v && cyc > busy_until) begin
         e.hi  = h;
         e.lo  = l;
         e.cyc = cyc + ((c[1] && b == 0) ? 0 : W);
         sbq.push_back(e);
         busy_until = e.cyc;
         $display("[TB] start ctl=%b op1=0x%h op2=0x%h accepted, expect hi=0x%h lo=0x%h at cycle %0d",
                  c, a, b, h, l, e.cyc);
      end else begin
         $display("[TB] start ctl=%b op1=0x%h op2=0x%h expected to be ignored", c, a, b);
      end
      op1 = $urandom; op2 = $urandom; control = 6'($urandom_range(0, 63));
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      if (!rst) begin
         exp_busy = (sbq.size() > 0) && (cyc < sbq[0].cyc);
         chk("busy", busy, exp_busy);
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", done, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               model_hi = e.hi;
               model_lo = e.lo;
               $display("[TB] done cycle %0d hi=0x%h lo=0x%h", cyc, hi, lo);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            chk("missing_done", done, 1);
            e = sbq.pop_front();
            model_hi = e.hi;
            model_lo = e.lo;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [5:0] codes[12] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLTU, F_MFHI, F_MFLO,
                             F_MULT, F_DIV, 6'b000111};

   initial begin
      logic [5:0]   c;
      logic [W-1:0] a, b;
      int           sel, mode;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      control = F_MFHI;
      #1;
      chk("rst_mfhi", result, 0);
      chk("rst_mfhi_zero", zero, 1);
      rst = 1'b0;
      busy_until = cyc;
      tick();

      control = F_SUB; op1 = 32'd5; op2 = 32'd5;
      #1;
      chk("sub_eq_result", result, 0);
      chk("sub_eq_zero", zero, 1);
      chk("sub_eq_busy", busy, 0);
      control = F_SLTU; op1 = 32'd3; op2 = 32'hFFFF_FFFF;
      #1;
      chk("sltu_result", result, 1);
      chk("sltu_zero", zero, 0);
      tick();

      issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (3) tick();
      issue(F_DIVU, 32'd100, 32'd7);
      control = F_MFLO;
      #1;
      chk("mflo_in_run", result, model_lo);
      wait_cyc(busy_until);
      issue(F_DIVU, 32'd100, 32'd7);
      control = F_MFLO;
      #1;
      chk("mflo_prev_in_run", result, 32'h0000_0001);
      control = F_MFHI;
      #1;
      chk("mfhi_prev_in_run", result, 32'hFFFF_FFFE);
      wait_cyc(busy_until);
      tick();
      control = F_MFLO;
      #1;
      chk("mflo_quot", result, 14);
      chk("mflo_quot_zero", zero, 0);
      tick();

      issue(F_DIVU, 32'h1234, 32'h0);
      tick();
      issue(F_MULTU, 32'd3, 32'd5);
      repeat (2) tick();
      issue(F_MULTU, 32'd7, 32'd7);
      wait_cyc(busy_until);
      tick();

      issue(F_MULTU, $urandom, $urandom);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sbq.delete();
      model_hi = '0;
      model_lo = '0;
      busy_until = cyc;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      repeat (3) tick();

      issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_cyc(busy_until);
      tick();
      issue(F_MULT, 32'hFFFF_FFFD, 32'd4);
      wait_cyc(busy_until);
      tick();
      control = F_DIV; op1 = 32'd9; op2 = 32'd3;
      #1;
      chk("div_code_result", result, 0);
      tick();

      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1: c = F_MULTU;
            2:    c = F_DIVU;
            3:    c = F_MULT;
            4:    c = F_DIV;
            default: c = 6'($urandom_range(0, 63));
         endcase
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 300);
         if ($urandom_range(0, 7) == 0) b = '0;
         mode = $urandom_range(0, 3);
         case (mode)
            0: begin wait_cyc(busy_until); issue(c, a, b); end
            1: issue(c, a, b);
            2: begin wait_cyc(busy_until); repeat (2) tick(); issue(c, a, b); end
            default: begin
               for (int k = 0; k < 3; k++) begin
                  control = codes[$urandom_range(0, 11)];
                  op1 = $urandom;
                  op2 = ($urandom_range(0, 3) == 0) ? op1 : $urandom;
                  #1;
                  if (sbq.size() == 0 || cyc < sbq[0].cyc) begin
                     chk("alu_result", result, alu_ref(control, op1, op2));
                     chk("alu_zero", zero, alu_ref(control, op1, op2) == 0);
                  end
                  tick();
               end
            end
         endcase
      end

      for (int k = 0; k < 100 && sbq.size() > 0; k++) tick();
      if (sbq.size() > 0) chk("drain", sbq.size(), 0);
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result bit width (legal range 8..64, even).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port op1  input  WIDTH  first operand (rs).
REQ-005 The block SHALL have port op2  input  WIDTH  second operand (rt).
REQ-006 The block SHALL have port control  input  6  MIPS funct code selecting the operation.
REQ-007 The block SHALL have port start  input  1  launch request for a multi-cycle multiply/divide.
REQ-008 The block SHALL have port result  output  WIDTH  combinational single-cycle result.
REQ-009 The block SHALL have port zero  output  1  high when result equals 0.
REQ-010 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse: HI/LO just updated.
REQ-012 The block SHALL have ports hi and lo  output  WIDTH each  registered HI/LO values.

Function
REQ-013 result SHALL be combinational: ADD 100000 op1+op2 (mod 2^WIDTH); SUB 100010 op1-op2; AND 100100; OR 100101; XOR 100110; NOR 100111; SLTU 101011 unsigned compare, zero-extended 1/0; MFHI 010000 hi; MFLO 010010 lo; any other code 0.
REQ-014 zero SHALL equal (result == 0) in every cycle, including while busy.
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-016 A start SHALL be accepted only in IDLE or DONE with control MULTU 011001 or DIVU 011011; op1/op2/control are latched at the accepting edge; the FSM moves to RUN.
REQ-017 start with any other control code, or while in RUN, SHALL be ignored with no state change.
REQ-018 RUN SHALL last exactly WIDTH cycles (one shift-add or restoring-subtract step per cycle), then DONE for exactly one cycle, then IDLE unless a new start is accepted in DONE.
REQ-019 MULTU SHALL write the 2*WIDTH-bit unsigned product: hi=upper half, lo=lower half.
REQ-020 DIVU SHALL write lo=unsigned quotient, hi=unsigned remainder.
REQ-021 DIVU with latched op2=0 SHALL skip RUN (IDLE->DONE next edge), writing lo=all ones, hi=latched op1.
REQ-022 hi/lo SHALL change only on the edge entering DONE; intermediate values SHALL NOT be visible on hi/lo during RUN.
REQ-023 MFHI/MFLO during RUN SHALL return the previous hi/lo values.
REQ-024 Changes on op1/op2/control after acceptance SHALL NOT affect the running operation.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0; rst overrides start.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse and hi/lo=0.

Configuration
REQ-027 Macro ALU_MULDIV_SIGNED_EN SHALL, when defined, add MULT 011000 and DIV 011010: operands treated as two's complement, magnitudes run through the unsigned datapath, signs corrected on entry to DONE; DIV quotient truncates toward zero, remainder takes op1's sign; same latency as unsigned; signed divide by zero follows REQ-021.
REQ-028 Without ALU_MULDIV_SIGNED_EN, 011000/011010 SHALL be treated as unknown codes: result 0, start ignored.

Verification
REQ-029 WIDTH=32, control=100010, op1=5, op2=5 -> result=0, zero=1, busy=0.
REQ-030 MULTU start, op1=0xFFFFFFFF, op2=0xFFFFFFFF -> busy high 32 cycles, done 33 cycles after the accept edge, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 DIVU op1=100, op2=7 -> lo=14, hi=2; then MFLO -> result=14; second start in the DONE cycle accepted back-to-back.
REQ-032 DIVU op2=0, op1=0x1234 -> done on next cycle, lo=0xFFFFFFFF, hi=0x1234; start during RUN of a MULTU ignored.
REQ-033 rst pulsed at RUN cycle 10 of a MULTU -> no done pulse, busy=0, hi=lo=0 next cycle.
REQ-034 With ALU_MULDIV_SIGNED_EN, DIV op1=-7, op2=2 -> lo=-3, hi=-1; MULT -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4; without the macro, the same start is ignored.
